// File: rtl/p12_cfg_loader_if.sv
// Serial configuration bitstream handshake for p12_cfg_loader.
// The bitstream source is the master; the loader is the slave.
interface p12_cfg_loader_if;
  logic din_bit;
  logic din_valid;
  logic din_ready;

  modport master (
    output din_bit,
    output din_valid,
    input  din_ready
  );

  modport slave (
    input  din_bit,
    input  din_valid,
    output din_ready
  );
endinterface

// File: rtl/p12_cfg_loader.sv
// p12_cfg_loader: configuration sequencer for the p12 tile array.
// Shifts one plane (V, H, D, FF-state) per pass through the tile scan chain,
// then pulses that plane's latch enable. All outputs are registered.
// Optional readback of the previous chain contents: define P12_CFG_READBACK_EN.
module p12_cfg_loader #(
  parameter int CHAIN_LEN = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [3:0]        plane_mask,
  input  logic              lb_run,
  p12_cfg_loader_if.slave   din,
  output logic              se,
  output logic              sc,
  output logic              lat_v,
  output logic              lat_h,
  output logic              lat_d,
  output logic              lb,
  output logic              busy,
  output logic              done,
  output logic              err
`ifdef P12_CFG_READBACK_EN
  ,
  input  logic              chain_tail,
  output logic              dout_bit,
  output logic              dout_valid
`endif
);

  localparam int CNT_W = $clog2(CHAIN_LEN);
  localparam logic [CNT_W:0] CNT_LAST = (CNT_W + 1)'(CHAIN_LEN - 1);
  localparam logic [CNT_W:0] CNT_ONE  = (CNT_W + 1)'(1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SHIFT,
    S_LATCH,
    S_ABORT,
    S_DONE
  } state_t;

  state_t         state_q, state_d;
  logic [CNT_W:0] cnt_q, cnt_d;
  logic [1:0]     plane_q, plane_d;
  logic [3:0]     mask_q, mask_d;
  logic           se_d, sc_d, lat_v_d, lat_h_d, lat_d_d, lb_d;
  logic           ready_d, busy_d, done_d, err_d;
  logic [2:0]     first_pick, next_pick;

  // Lowest set plane at or above 'from': {found, index}.
  function automatic logic [2:0] pick(input logic [3:0] m, input logic [2:0] from);
    logic found;
    found = 1'b0;
    pick  = '0;
    for (int unsigned k = 0; k < 4; k++) begin
      if (!found && (k >= {29'd0, from}) && m[k]) begin
        found = 1'b1;
        pick  = {1'b1, k[1:0]};
      end
    end
  endfunction

  // Next-state and next-output decode.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    plane_d    = plane_q;
    mask_d     = mask_q;
    se_d       = 1'b0;
    sc_d       = 1'b0;
    lat_v_d    = 1'b0;
    lat_h_d    = 1'b0;
    lat_d_d    = 1'b0;
    lb_d       = 1'b1;
    ready_d    = 1'b0;
    busy_d     = 1'b0;
    done_d     = done;
    err_d      = err;
    first_pick = pick(plane_mask, 3'd0);
    next_pick  = pick(mask_q, {1'b0, plane_q} + 3'd1);

    case (state_q)
      S_IDLE, S_DONE: begin
        lb_d = lb_run;
        if (start) begin
          done_d = 1'b0;
          err_d  = 1'b0;
          mask_d = plane_mask;
          lb_d   = 1'b1;
          if (first_pick[2]) begin
            state_d = S_SHIFT;
            plane_d = first_pick[1:0];
            cnt_d   = '0;
            busy_d  = 1'b1;
            ready_d = 1'b1;
          end else begin
            state_d = S_DONE;
            done_d  = 1'b1;
          end
        end
      end

      S_SHIFT: begin
        if (din.din_valid) begin
          se_d   = 1'b1;
          sc_d   = din.din_bit;
          cnt_d  = cnt_q + CNT_ONE;
          busy_d = 1'b1;
          if (cnt_q == CNT_LAST) begin
            // FF-state is the last plane and has no latch enable.
            if (plane_q == 2'd3) begin
              state_d = S_DONE;
              done_d  = 1'b1;
              busy_d  = 1'b0;
            end else begin
              state_d = S_LATCH;
            end
          end else begin
            ready_d = 1'b1;
          end
        end else begin
          // Chain shifts every clock while se=1, so a gap corrupts the plane.
          state_d = S_ABORT;
          err_d   = 1'b1;
        end
      end

      S_LATCH: begin
        lat_v_d = (plane_q == 2'd0);
        lat_h_d = (plane_q == 2'd1);
        lat_d_d = (plane_q == 2'd2);
        if (next_pick[2]) begin
          state_d = S_SHIFT;
          plane_d = next_pick[1:0];
          cnt_d   = '0;
          busy_d  = 1'b1;
          ready_d = 1'b1;
        end else begin
          state_d = S_DONE;
          done_d  = 1'b1;
        end
      end

      S_ABORT: begin
        state_d = S_IDLE;
        err_d   = 1'b1;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State and registered output update.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= S_IDLE;
      cnt_q         <= '0;
      plane_q       <= '0;
      mask_q        <= '0;
      se            <= 1'b0;
      sc            <= 1'b0;
      lat_v         <= 1'b0;
      lat_h         <= 1'b0;
      lat_d         <= 1'b0;
      lb            <= 1'b1;
      din.din_ready <= 1'b0;
      busy          <= 1'b0;
      done          <= 1'b0;
      err           <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      plane_q       <= plane_d;
      mask_q        <= mask_d;
      se            <= se_d;
      sc            <= sc_d;
      lat_v         <= lat_v_d;
      lat_h         <= lat_h_d;
      lat_d         <= lat_d_d;
      lb            <= lb_d;
      din.din_ready <= ready_d;
      busy          <= busy_d;
      done          <= done_d;
      err           <= err_d;
    end
  end

`ifdef P12_CFG_READBACK_EN
  // Stream the previous chain contents out, one bit per accepted input bit.
  always_ff @(posedge clk) begin
    if (rst) begin
      dout_valid <= 1'b0;
      dout_bit   <= 1'b0;
    end else begin
      dout_valid <= (state_q == S_SHIFT) && din.din_valid;
      dout_bit   <= chain_tail;
    end
  end
`endif

endmodule

// File: tb/tb_p12_cfg_loader.sv
// Self-checking bench for p12_cfg_loader (CHAIN_LEN=4).
module tb_p12_cfg_loader;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic [3:0] plane_mask;
  logic       lb_run;
  logic       se, sc, lat_v, lat_h, lat_d, lb, busy, done, err;
`ifdef P12_CFG_READBACK_EN
  logic        chain_tail;
  logic        dout_bit, dout_valid;
  logic [15:0] tb_tail;
  logic [15:0] o_dout;
  int          o_ndout;
`endif

  p12_cfg_loader_if din_if ();

  p12_cfg_loader #(.CHAIN_LEN(4)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .plane_mask (plane_mask),
    .lb_run     (lb_run),
    .din        (din_if.slave),
    .se         (se),
    .sc         (sc),
    .lat_v      (lat_v),
    .lat_h      (lat_h),
    .lat_d      (lat_d),
    .lb         (lb),
    .busy       (busy),
    .done       (done),
    .err        (err)
`ifdef P12_CFG_READBACK_EN
    ,
    .chain_tail (chain_tail),
    .dout_bit   (dout_bit),
    .dout_valid (dout_valid)
`endif
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  typedef struct {
    logic [3:0]  mask;
    logic [15:0] bits;
    int          nbits;
    int          poke;
    int          exp_sh;
    logic [15:0] exp_sc;
    logic [11:0] exp_lat;
    int          exp_busy;
    logic        exp_done;
    logic        exp_err;
  } vec_t;

  // Results of one pass
  logic [31:0] o_sc;
  int          o_nsh;
  logic [11:0] o_lat;
  int          o_busy;
  logic        o_done, o_err, o_to, o_lbbad, o_selat, o_errclr;

  task automatic run_pass(input logic [3:0] m, input logic [15:0] b, input int nb, input int poke);
    int   idx;
    logic acc;
    logic ended;
    idx = 0; acc = 1'b0; ended = 1'b0;
    o_sc = '0; o_nsh = 0; o_lat = '0; o_busy = 0;
    o_done = 1'b0; o_err = 1'b0; o_to = 1'b1; o_lbbad = 1'b0; o_selat = 1'b0; o_errclr = 1'b1;
`ifdef P12_CFG_READBACK_EN
    o_dout = '0; o_ndout = 0;
`endif
    @(negedge clk);
    start = 1'b1; plane_mask = m; din_if.din_valid = 1'b0;
    for (int c = 0; c < 80 && !ended; c++) begin
      @(negedge clk);
      start = (c == poke);
      plane_mask = (c == poke) ? 4'hF : m;
      if (c == 0 && err) o_errclr = 1'b0;
      if (se && o_nsh < 32) begin o_sc[o_nsh] = sc; o_nsh++; end
      if (lat_v | lat_h | lat_d) begin
        o_lat = {o_lat[8:0], lat_d, lat_h, lat_v};
        if (se || ($countones({lat_d, lat_h, lat_v}) != 1)) o_selat = 1'b1;
      end
      if (busy) begin o_busy++; if (!lb) o_lbbad = 1'b1; end
`ifdef P12_CFG_READBACK_EN
      if (dout_valid && o_ndout < 16) begin o_dout[o_ndout] = dout_bit; o_ndout++; end
`endif
      if (acc) idx++;
      din_if.din_valid = (idx < nb);
      din_if.din_bit   = (idx < nb) ? b[idx] : 1'b0;
`ifdef P12_CFG_READBACK_EN
      chain_tail = (idx < 16) ? tb_tail[idx] : 1'b0;
`endif
      acc = din_if.din_ready && din_if.din_valid;
      if (done || err) begin
        ended = 1'b1; o_to = 1'b0; o_done = done; o_err = err;
        if (!lb) o_lbbad = 1'b1;
      end
    end
    din_if.din_valid = 1'b0;
    start = 1'b0;
  endtask

  vec_t vecs[8];
  logic bad;

  initial begin
    vecs[0] = '{4'b0001, 16'h000D, 4,  -1, 4,  16'h000D, 12'b000_000_001, 5,  1'b1, 1'b0};
    vecs[1] = '{4'b1111, 16'hA5C3, 16, -1, 16, 16'hA5C3, 12'b001_010_100, 19, 1'b1, 1'b0};
    vecs[2] = '{4'b0000, 16'h0000, 0,  -1, 0,  16'h0000, 12'b000_000_000, 0,  1'b1, 1'b0};
    vecs[3] = '{4'b1000, 16'h0006, 4,  -1, 4,  16'h0006, 12'b000_000_000, 4,  1'b1, 1'b0};
    vecs[4] = '{4'b0110, 16'h00B4, 8,  -1, 8,  16'h00B4, 12'b000_010_100, 10, 1'b1, 1'b0};
    vecs[5] = '{4'b0101, 16'h003C, 8,  -1, 8,  16'h003C, 12'b000_001_100, 10, 1'b1, 1'b0};
    vecs[6] = '{4'b0010, 16'h0003, 2,  -1, 2,  16'h0003, 12'b000_000_000, 3,  1'b0, 1'b1};
    vecs[7] = '{4'b0001, 16'h000D, 4,  2,  4,  16'h000D, 12'b000_000_001, 5,  1'b1, 1'b0};

    rst = 1'b1; start = 1'b0; plane_mask = '0; lb_run = 1'b0;
    din_if.din_bit = 1'b0; din_if.din_valid = 1'b0;
`ifdef P12_CFG_READBACK_EN
    chain_tail = 1'b0;
    tb_tail = 16'b0011;
`endif

    // Reset values
    @(negedge clk);
    @(negedge clk);
    chk("rst_se", {31'd0, se}, 0);
    chk("rst_lat", {29'd0, lat_d, lat_h, lat_v}, 0);
    chk("rst_lb", {31'd0, lb}, 1);
    chk("rst_busy", {31'd0, busy}, 0);
    chk("rst_done", {31'd0, done}, 0);
    chk("rst_err", {31'd0, err}, 0);
    chk("rst_ready", {31'd0, din_if.din_ready}, 0);
    rst = 1'b0;
    @(negedge clk);
    chk("lb_follow_after_rst", {31'd0, lb}, 0);

    // Table-driven passes
    for (int i = 0; i < 8; i++) begin
      run_pass(vecs[i].mask, vecs[i].bits, vecs[i].nbits, vecs[i].poke);
      chk($sformatf("v%0d_timeout", i), {31'd0, o_to}, 0);
      chk($sformatf("v%0d_nshift", i), o_nsh, vecs[i].exp_sh);
      chk($sformatf("v%0d_sc", i), o_sc, {16'd0, vecs[i].exp_sc});
      chk($sformatf("v%0d_latseq", i), {20'd0, o_lat}, {20'd0, vecs[i].exp_lat});
      chk($sformatf("v%0d_busycyc", i), o_busy, vecs[i].exp_busy);
      chk($sformatf("v%0d_done", i), {31'd0, o_done}, {31'd0, vecs[i].exp_done});
      chk($sformatf("v%0d_err", i), {31'd0, o_err}, {31'd0, vecs[i].exp_err});
      chk($sformatf("v%0d_lb_hold", i), {31'd0, o_lbbad}, 0);
      chk($sformatf("v%0d_lat_se", i), {31'd0, o_selat}, 0);
      chk($sformatf("v%0d_errclr", i), {31'd0, o_errclr}, 1);
`ifdef P12_CFG_READBACK_EN
      if (i == 0) begin
        chk("rb_count", o_ndout, 4);
        chk("rb_bits", {16'd0, o_dout}, 32'h3);
      end
`endif
      @(negedge clk);
      if (vecs[i].exp_err) begin
        chk($sformatf("v%0d_idle_ready", i), {31'd0, din_if.din_ready}, 0);
        chk($sformatf("v%0d_idle_busy", i), {31'd0, busy}, 0);
        chk($sformatf("v%0d_err_sticky", i), {31'd0, err}, 1);
        chk($sformatf("v%0d_no_lat", i), {29'd0, lat_d, lat_h, lat_v}, 0);
      end else begin
        chk($sformatf("v%0d_lb_run", i), {31'd0, lb}, 0);
      end
    end

    // Reset in the middle of a shift pass
    @(negedge clk);
    start = 1'b1; plane_mask = 4'hF; din_if.din_valid = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      start = 1'b0;
      din_if.din_valid = 1'b1;
      din_if.din_bit = c[0];
      if (c == 2) rst = 1'b1;
    end
    @(negedge clk);
    rst = 1'b0;
    chk("midrst_se", {31'd0, se}, 0);
    chk("midrst_lat", {29'd0, lat_d, lat_h, lat_v}, 0);
    chk("midrst_lb", {31'd0, lb}, 1);
    chk("midrst_busy", {31'd0, busy}, 0);
    chk("midrst_done", {31'd0, done}, 0);
    chk("midrst_err", {31'd0, err}, 0);
    chk("midrst_ready", {31'd0, din_if.din_ready}, 0);
    bad = 1'b0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      if (se || lat_v || lat_h || lat_d || busy) bad = 1'b1;
    end
    chk("midrst_quiet", {31'd0, bad}, 0);
    din_if.din_valid = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
